// File: rtl/axi_pkg.sv
// Shared AXI definitions for the aligned read/write masters: FSM state
// encodings, RRESP codes, burst limits and the burst-length helper.
package axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PAGE_BYTES      = 4096;
    localparam int MAX_BURST_BEATS = 256;

    // ARLEN/AWLEN = min(beats-1, 255, beats left before the 4 KB page end).
    // beats is never zero when this is used.
    function automatic logic [7:0] burst_len(input logic [31:0] beats,
                                             input logic [31:0] room);
        logic [31:0] len;
        len = beats - 32'd1;
        if (len > 32'(MAX_BURST_BEATS - 1))
            len = 32'(MAX_BURST_BEATS - 1);
        if (room < len)
            len = room;
        return len[7:0];
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer. Output side is driven purely from registers and
// in_ready depends only on the fill level, so there is no combinational
// path from out_ready back to in_ready.
module axi_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign empty     = (count == 2'd0);

    // Storage, pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axi_master_v4_read_aligned.sv
// AXI4 read master for beat-aligned transfers. Splits a byte request into
// INCR bursts (<= 256 beats, never crossing 4 KB) with one burst in flight.
// Optional macro AXI_RD_SKID_EN: registered 2-entry skid buffer on the user
// side instead of the combinational R passthrough.
//
//  state  | meaning
//  IDLE   | waiting for a request with a nonzero beat count
//  ADDR   | load AR fields, then hold ARVALID until ARREADY
//  DATA   | receiving the current burst, counted by r_cnt
module axi_master_v4_read_aligned
    import axi_pkg::*;
#(
    parameter int D_POWER = 3,
    parameter int D_WIDTH = 8 * (1 << D_POWER),
    parameter int B_WIDTH = 1 << D_POWER
) (
    input  logic               sys_clock,
    input  logic               async_reset,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_len,
    input  logic               i_req,
    output logic               or_busy,
    output logic [1:0]         or_err,
    output logic [D_WIDTH-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [31:0]        or_ar_addr,
    output logic [7:0]         or_ar_len,
    output logic [2:0]         o_ar_size,
    output logic               or_ar_valid,
    input  logic               i_ar_ready,
    input  logic [D_WIDTH-1:0] i_r_data,
    input  logic [1:0]         i_r_resp,
    input  logic               i_r_last,
    input  logic               i_r_valid,
    output logic               o_r_ready
);

    localparam int          AW            = 32 - D_POWER;
    localparam logic [31:0] PAGE_BEATS_M1 = 32'(PAGE_BYTES / B_WIDTH) - 32'd1;

    state_t         state, state_next;
    logic [31:D_POWER] r_addr;
    logic [AW-1:0]  r_beats;
    logic [7:0]     r_cnt;

    logic [AW-1:0]  beats_in;
    logic [AW-1:0]  beats_left;
    logic [31:0]    room;
    logic [7:0]     len_calc;
    logic           accept;
    logic           r_ready;
    logic           r_hs;
    logic           last_of_burst;
    logic           resp_err;
    logic           busy_done;
    logic           unused_ok;

    assign o_ar_size     = 3'(D_POWER);
    assign beats_in      = i_len[31:D_POWER];
    assign beats_left    = r_beats - AW'(1);
    assign room          = PAGE_BEATS_M1 - 32'(r_addr[11:D_POWER]);
    assign len_calc      = burst_len(32'(r_beats), room);
    assign accept        = (state == S_IDLE) && i_req && !or_busy && (beats_in != '0);
    assign r_hs          = i_r_valid & r_ready;
    assign last_of_burst = r_hs && (r_cnt == 8'd0);
    assign unused_ok     = ^{i_addr[D_POWER-1:0], i_len[D_POWER-1:0]};

`ifdef AXI_RD_SKID_EN
    logic skid_in_ready;
    logic skid_empty;

    assign r_ready   = skid_in_ready & (state == S_DATA);
    // Busy holds until the user has drained everything already taken from R.
    assign busy_done = (state == S_IDLE) && or_busy && skid_empty;

    axi_skid_buffer #(.WIDTH(D_WIDTH)) u_skid (
        .clk       (sys_clock),
        .rst_n     (async_reset),
        .in_data   (i_r_data),
        .in_valid  (i_r_valid & (state == S_DATA)),
        .in_ready  (skid_in_ready),
        .out_data  (o_data),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .empty     (skid_empty)
    );
`else
    assign o_data    = i_r_data;
    assign o_valid   = i_r_valid & (state == S_DATA);
    assign r_ready   = i_ready & (state == S_DATA);
    // In passthrough the final R handshake is also the final user accept.
    assign busy_done = last_of_burst && (beats_left == '0);
`endif

    assign o_r_ready = r_ready;

    // Any SLVERR/DECERR sets the sticky response error bit.
    always_comb begin
        resp_err = 1'b0;
        case (i_r_resp)
            RESP_OKAY, RESP_EXOKAY:   resp_err = 1'b0;
            RESP_SLVERR, RESP_DECERR: resp_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clock or negedge async_reset) begin
        if (!async_reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; burst end comes from r_cnt, RLAST is only checked.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_ADDR;
            S_ADDR: if (or_ar_valid && i_ar_ready) state_next = S_DATA;
            S_DATA: if (last_of_burst) state_next = (beats_left != '0) ? S_ADDR : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, AR channel registers, beat counters and status flags.
    always_ff @(posedge sys_clock or negedge async_reset) begin
        if (!async_reset) begin
            r_addr      <= '0;
            r_beats     <= '0;
            r_cnt       <= 8'd0;
            or_ar_addr  <= 32'd0;
            or_ar_len   <= 8'd0;
            or_ar_valid <= 1'b0;
            or_busy     <= 1'b0;
            or_err      <= 2'b00;
        end else begin
            if (accept) begin
                r_addr  <= i_addr[31:D_POWER];
                r_beats <= beats_in;
                or_err  <= 2'b00;
                or_busy <= 1'b1;
            end else if (busy_done) begin
                or_busy <= 1'b0;
            end

            // First ADDR cycle loads the AR fields; they stay frozen while ARVALID is up.
            if (state == S_ADDR) begin
                if (!or_ar_valid) begin
                    or_ar_addr  <= {r_addr, {D_POWER{1'b0}}};
                    or_ar_len   <= len_calc;
                    or_ar_valid <= 1'b1;
                end else if (i_ar_ready) begin
                    or_ar_valid <= 1'b0;
                    r_addr      <= r_addr + AW'(or_ar_len) + AW'(1);
                    r_cnt       <= or_ar_len;
                end
            end

            if (r_hs) begin
                r_beats   <= beats_left;
                or_err[1] <= or_err[1] | resp_err;
                or_err[0] <= or_err[0] | (i_r_last != (r_cnt == 8'd0));
                if (r_cnt != 8'd0)
                    r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_master_v4_read_aligned.sv
// Scoreboard bench for axi_master_v4_read_aligned (default passthrough build).
// Stimulus pushes expected AR commands and data beats; monitors pop/compare.
module tb_axi_master_v4_read_aligned;

    localparam int DP = 3;
    localparam int DW = 64;

    logic          sys_clock = 1'b0;
    logic          async_reset = 1'b0;
    logic [31:0]   i_addr = 32'd0;
    logic [31:0]   i_len = 32'd0;
    logic          i_req = 1'b0;
    logic          or_busy;
    logic [1:0]    or_err;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   or_ar_addr;
    logic [7:0]    or_ar_len;
    logic [2:0]    o_ar_size;
    logic          or_ar_valid;
    logic          i_ar_ready;
    logic [DW-1:0] i_r_data;
    logic [1:0]    i_r_resp;
    logic          i_r_last;
    logic          i_r_valid;
    logic          o_r_ready;

    always #5 sys_clock = ~sys_clock;

    axi_master_v4_read_aligned #(.D_POWER(DP)) dut (
        .sys_clock   (sys_clock),
        .async_reset (async_reset),
        .i_addr      (i_addr),
        .i_len       (i_len),
        .i_req       (i_req),
        .or_busy     (or_busy),
        .or_err      (or_err),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .or_ar_addr  (or_ar_addr),
        .or_ar_len   (or_ar_len),
        .o_ar_size   (o_ar_size),
        .or_ar_valid (or_ar_valid),
        .i_ar_ready  (i_ar_ready),
        .i_r_data    (i_r_data),
        .i_r_resp    (i_r_resp),
        .i_r_last    (i_r_last),
        .i_r_valid   (i_r_valid),
        .o_r_ready   (o_r_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic [DW-1:0] exp_q[$];
    ar_t           ar_exp_q[$];
    ar_t           slv_q[$];

    int checks = 0;
    int errors = 0;

    bit stall_en = 1'b0;
    int err_idx  = -1;
    int last_idx = -1;
    int gbeat    = 0;
    int cur_beat = 0;

    function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave memory model: accepts AR, returns beats with optional stalls and injected faults.
    initial begin : slave
        bit          ar_hs, r_hs;
        ar_t         ar_c;
        logic [31:0] a;
        i_ar_ready = 1'b0;
        i_r_valid  = 1'b0;
        i_r_data   = '0;
        i_r_resp   = 2'b00;
        i_r_last   = 1'b0;
        i_ready    = 1'b0;
        forever begin
            @(negedge sys_clock);
            ar_hs    = or_ar_valid && i_ar_ready;
            ar_c.addr = or_ar_addr;
            ar_c.len  = or_ar_len;
            r_hs     = i_r_valid && o_r_ready;
            @(posedge sys_clock);
            #1;
            if (!async_reset) begin
                slv_q.delete();
                cur_beat   = 0;
                i_ar_ready = 1'b0;
                i_r_valid  = 1'b0;
                i_r_last   = 1'b0;
                i_r_resp   = 2'b00;
                i_ready    = 1'b0;
                continue;
            end
            if (r_hs && slv_q.size() > 0) begin
                gbeat++;
                if (cur_beat == int'(slv_q[0].len)) begin
                    void'(slv_q.pop_front());
                    cur_beat = 0;
                end else begin
                    cur_beat++;
                end
            end
            if (ar_hs)
                slv_q.push_back(ar_c);
            i_ar_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_ready    = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (slv_q.size() > 0) begin
                a         = slv_q[0].addr + 32'(cur_beat * 8);
                i_r_valid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                i_r_data  = mem_word(a);
                i_r_resp  = (gbeat == err_idx) ? 2'b10 : 2'b00;
                i_r_last  = (cur_beat == int'(slv_q[0].len)) ^ (gbeat == last_idx);
            end else begin
                i_r_valid = 1'b0;
                i_r_last  = 1'b0;
                i_r_resp  = 2'b00;
            end
        end
    end

    // Monitor: compares delivered beats and AR commands against the scoreboard queues.
    initial begin : monitor
        bit  ar_pend = 1'b0;
        ar_t held;
        ar_t e;
        forever begin
            @(negedge sys_clock);
            if (!async_reset) begin
                ar_pend = 1'b0;
                continue;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_extra: got %h expected no beat", o_data);
                end else begin
                    check("data", o_data, exp_q.pop_front());
                end
            end
            if (ar_pend) begin
                check("ar_hold_valid", 64'(or_ar_valid), 64'(1));
                check("ar_hold_addr", 64'(or_ar_addr), 64'(held.addr));
                check("ar_hold_len", 64'(or_ar_len), 64'(held.len));
            end
            if (or_ar_valid && i_ar_ready) begin
                if (ar_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_extra: got addr %h len %0d expected none", or_ar_addr, or_ar_len);
                end else begin
                    e = ar_exp_q.pop_front();
                    check("ar_addr", 64'(or_ar_addr), 64'(e.addr));
                    check("ar_len", 64'(or_ar_len), 64'(e.len));
                    check("ar_size", 64'(o_ar_size), 64'(3));
                end
            end
            ar_pend   = or_ar_valid && !i_ar_ready;
            held.addr = or_ar_addr;
            held.len  = or_ar_len;
        end
    end

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        ar_t t;
        t.addr = addr;
        t.len  = len;
        ar_exp_q.push_back(t);
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] len, input bit stall,
                         input int e_idx, input int l_idx);
        int beats;
        beats    = int'(len >> 3);
        stall_en = stall;
        err_idx  = e_idx;
        last_idx = l_idx;
        gbeat    = 0;
        for (int i = 0; i < beats; i++)
            exp_q.push_back(mem_word((addr & ~32'h7) + 32'(i * 8)));
        @(posedge sys_clock);
        #1;
        i_addr = addr;
        i_len  = len;
        i_req  = 1'b1;
        @(posedge sys_clock);
        #1;
        i_req = 1'b0;
        check("busy_on", 64'(or_busy), 64'(1));
        check("err_cleared", 64'(or_err), 64'(0));
    endtask

    task automatic run_req(input logic [31:0] addr, input logic [31:0] len, input bit stall,
                           input int e_idx, input int l_idx, input logic [1:0] exp_err);
        int cyc;
        issue(addr, len, stall, e_idx, l_idx);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20000) begin
            @(posedge sys_clock);
            #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d beats still expected for addr %h", exp_q.size(), addr);
            exp_q.delete();
        end
        check("busy_off", 64'(or_busy), 64'(0));
        check("err_final", 64'(or_err), 64'(exp_err));
        check("ar_all_issued", 64'(ar_exp_q.size()), 64'(0));
    endtask

    initial begin : stimulus
        int cyc;
        repeat (3) @(negedge sys_clock);
        check("rst_busy", 64'(or_busy), 64'(0));
        check("rst_err", 64'(or_err), 64'(0));
        check("rst_ar_valid", 64'(or_ar_valid), 64'(0));
        check("rst_ar_addr", 64'(or_ar_addr), 64'(0));
        check("rst_ar_len", 64'(or_ar_len), 64'(0));
        check("rst_o_valid", 64'(o_valid), 64'(0));
        check("rst_r_ready", 64'(o_r_ready), 64'(0));
        async_reset = 1'b1;

        // Single aligned burst.
        push_ar(32'h0000_1000, 8'd7);
        run_req(32'h0000_1000, 32'd64, 1'b0, -1, -1, 2'b00);

        // 4 KB split: 2 beats before the page end, 6 after.
        push_ar(32'h0000_0FF0, 8'd1);
        push_ar(32'h0000_1000, 8'd5);
        run_req(32'h0000_0FF0, 32'd64, 1'b0, -1, -1, 2'b00);

        // 512 beats: two maximum-length bursts.
        push_ar(32'h0000_0000, 8'd255);
        push_ar(32'h0000_0800, 8'd255);
        run_req(32'h0000_0000, 32'd4096, 1'b0, -1, -1, 2'b00);

        // Sub-beat length is ignored.
        @(posedge sys_clock);
        #1;
        i_addr = 32'h0000_7000;
        i_len  = 32'd4;
        i_req  = 1'b1;
        @(posedge sys_clock);
        #1;
        i_req = 1'b0;
        repeat (4) begin
            @(negedge sys_clock);
            check("zero_len_busy", 64'(or_busy), 64'(0));
            check("zero_len_ar_valid", 64'(or_ar_valid), 64'(0));
        end

        // 300 beats with random stalls on every handshake.
        push_ar(32'h0000_3F00, 8'd31);
        push_ar(32'h0000_4000, 8'd255);
        push_ar(32'h0000_4800, 8'd11);
        run_req(32'h0000_3F00, 32'd2400, 1'b1, -1, -1, 2'b00);

        // SLVERR on beat 3, early RLAST on beat 5.
        push_ar(32'h0000_6000, 8'd7);
        run_req(32'h0000_6000, 32'd64, 1'b0, 2, 4, 2'b11);

        // Reset in the middle of a burst; the request itself clears or_err.
        push_ar(32'h0000_5000, 8'd7);
        issue(32'h0000_5000, 32'd64, 1'b0, -1, -1);
        cyc = 0;
        while (exp_q.size() > 5 && cyc < 200) begin
            @(posedge sys_clock);
            #1;
            cyc++;
        end
        check("mid_data_state", 64'(o_r_ready), 64'(1));
        async_reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(or_busy), 64'(0));
        check("mid_rst_ar_valid", 64'(or_ar_valid), 64'(0));
        check("mid_rst_ar_addr", 64'(or_ar_addr), 64'(0));
        check("mid_rst_ar_len", 64'(or_ar_len), 64'(0));
        check("mid_rst_o_valid", 64'(o_valid), 64'(0));
        check("mid_rst_r_ready", 64'(o_r_ready), 64'(0));
        check("mid_rst_err", 64'(or_err), 64'(0));
        exp_q.delete();
        ar_exp_q.delete();
        repeat (3) @(negedge sys_clock);
        async_reset = 1'b1;

        push_ar(32'h0000_2000, 8'd0);
        run_req(32'h0000_2000, 32'd8, 1'b0, -1, -1, 2'b00);

        repeat (3) @(posedge sys_clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
